// File: rtl/rv32v_element_sequencer.sv
// rv32v_element_sequencer
//
// Walks one vector instruction's elements through the two-lane execute
// datapath, one beat per element pair. Lane 0 takes the even element
// (woffset0 = 2k), lane 1 the odd element (woffset1 = 2k+1). Beats hold
// while a lane is busy or the hazard unit stalls; flush abandons the
// instruction without a done pulse.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start, vl_in,   issue request (taken only when ready), element count,
//   vm_ena_in       and masked-instruction flag
//   ready           sequencer idle and able to accept start
//   mask_pair       v0 mask bits for the current woffset0/woffset1
//   lane_busy,      hold the current beat (lane multi-cycle op / hazard
//   stall, flush    stall); flush aborts to IDLE
//   beat_valid      woffset0/woffset1/wen describe a live beat
//   woffset0/1      lane 0 / lane 1 element index
//   wen             per-lane element write enable
//   last            current beat is the final one of the instruction
//   done            one-cycle pulse after the final beat retires
//   busy, next_busy current / next state is not IDLE
module rv32v_element_sequencer #(
  parameter int VL_W = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [VL_W-1:0] vl_in,
  input  logic            vm_ena_in,
  output logic            ready,
  input  logic [1:0]      mask_pair,
  input  logic            lane_busy,
  input  logic            stall,
  input  logic            flush,
  output logic            beat_valid,
  output logic [VL_W-1:0] woffset0,
  output logic [VL_W-1:0] woffset1,
  output logic [1:0]      wen,
  output logic            last,
  output logic            done,
  output logic            busy,
  output logic            next_busy
);

  // k counts element pairs, so it needs one bit less than an element index.
  localparam int K_W = VL_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [K_W-1:0]  k_reg, k_next;
  logic [VL_W-1:0] vl_reg, vl_next;
  logic            vm_reg, vm_next;

  logic            adv;
  logic [VL_W:0]   off_plus2;

  // Offsets are just k with the lane number appended as the low bit.
  assign woffset0 = {k_reg, 1'b0};
  assign woffset1 = {k_reg, 1'b1};

  assign ready      = (state_reg == IDLE);
  assign beat_valid = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);

  // One extra bit so 2k+2 cannot wrap below vl near the top of the range.
  assign off_plus2 = {1'b0, woffset0} + (VL_W+1)'(2);
  assign last      = beat_valid & (off_plus2 >= {1'b0, vl_reg});

  assign adv = beat_valid & ~stall & ~lane_busy & ~flush;

  // Per-lane write enable: lane 1 also drops out on the tail beat of an
  // odd vl, whatever the mask says.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic in_range;
      if (gi == 0) begin : g_even
        assign in_range = 1'b1;
      end else begin : g_odd
        assign in_range = (woffset1 < vl_reg);
      end
      assign wen[gi] = beat_valid & in_range & (~vm_reg | mask_pair[gi]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    vl_next    = vl_reg;
    vm_next    = vm_reg;
    unique case (state_reg)
      IDLE: begin
        // A flush in IDLE wins over a simultaneous start.
        if (start && !flush) begin
          if (vl_in != '0) begin
            state_next = RUN;
            vl_next    = vl_in;
            vm_next    = vm_ena_in;
            k_next     = '0;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
          k_next     = '0;
        end else if (adv) begin
          if (last) begin
            state_next = DONE;
            k_next     = '0;
          end else begin
            k_next = k_reg + K_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
      end
    endcase
  end

  // Reset forces IDLE on the next edge, so report that to the hazard unit.
  assign next_busy = ~RST & (state_next != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      vl_reg    <= '0;
      vm_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      vl_reg    <= vl_next;
      vm_reg    <= vm_next;
    end
  end

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
module tb_rv32v_element_sequencer;

  localparam int VL_W = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic [VL_W-1:0] vl_in;
  logic            vm_ena_in;
  logic            ready;
  logic [1:0]      mask_pair;
  logic            lane_busy;
  logic            stall;
  logic            flush;
  logic            beat_valid;
  logic [VL_W-1:0] woffset0;
  logic [VL_W-1:0] woffset1;
  logic [1:0]      wen;
  logic            last;
  logic            done;
  logic            busy;
  logic            next_busy;

  always #5 CLK = ~CLK;

  rv32v_element_sequencer #(.VL_W(VL_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .vl_in(vl_in), .vm_ena_in(vm_ena_in),
    .ready(ready), .mask_pair(mask_pair), .lane_busy(lane_busy), .stall(stall),
    .flush(flush), .beat_valid(beat_valid), .woffset0(woffset0),
    .woffset1(woffset1), .wen(wen), .last(last), .done(done), .busy(busy),
    .next_busy(next_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = issuing beats, 2 = done pulse.
  // m_beat is the number of element pairs already retired this instruction.
  int m_phase = 0;
  int m_beat  = 0;
  int m_vl    = 0;
  bit m_vm    = 0;

  // Observed counts for directed scenarios.
  int obs_beats = 0;
  int obs_dones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pairs_needed(input int vl);
    return (vl + 1) / 2;
  endfunction

  // Next phase following the behavioural rules, given current inputs.
  function automatic int model_next_phase();
    if (RST) return 0;
    case (m_phase)
      0: if (start && !flush) return (vl_in != 0) ? 1 : 2;
         else return 0;
      1: if (flush) return 0;
         else if (!stall && !lane_busy && (m_beat + 1 >= pairs_needed(m_vl))) return 2;
         else return 1;
      default: return 0;
    endcase
  endfunction

  task automatic compare_all();
    bit bv, w0, w1, lst;
    int o0, o1, np;
    bv  = (m_phase == 1);
    o0  = (2 * m_beat) % 256;
    o1  = (2 * m_beat + 1) % 256;
    w0  = bv && (!m_vm || mask_pair[0]);
    w1  = bv && (2 * m_beat + 1 < m_vl) && (!m_vm || mask_pair[1]);
    lst = bv && (m_beat + 1 >= pairs_needed(m_vl));
    np  = model_next_phase();
    check("ready",      32'(ready),      32'(m_phase == 0));
    check("beat_valid", 32'(beat_valid), 32'(bv));
    check("woffset0",   32'(woffset0),   32'(o0));
    check("woffset1",   32'(woffset1),   32'(o1));
    check("wen",        32'(wen),        32'({w1, w0}));
    check("last",       32'(last),       32'(lst));
    check("done",       32'(done),       32'(m_phase == 2));
    check("busy",       32'(busy),       32'(m_phase != 0));
    check("next_busy",  32'(next_busy),  32'(np != 0));
  endtask

  task automatic model_advance();
    int np;
    np = model_next_phase();
    if (RST) begin
      m_beat = 0; m_vl = 0; m_vm = 0;
    end else if (m_phase == 0 && np == 1) begin
      m_vl = int'(vl_in); m_vm = vm_ena_in; m_beat = 0;
      $display("issue vl=%0d vm=%0d t=%0t", vl_in, vm_ena_in, $time);
    end else if (m_phase == 0 && np == 2) begin
      $display("issue vl=0 (empty) t=%0t", $time);
    end else if (m_phase == 1) begin
      if (np != 1) m_beat = 0;
      else if (!stall && !lane_busy) m_beat++;
      if (np == 2) $display("retire vl=%0d vm=%0d t=%0t", m_vl, m_vm, $time);
      if (np == 0 && !RST) $display("flushed vl=%0d t=%0t", m_vl, $time);
    end
    m_phase = np;
  endtask

  // One clock: check at the falling edge, then advance the model and let
  // the DUT take the same edge; inputs may change 1 ns after it.
  task automatic tick();
    @(negedge CLK);
    compare_all();
    if (beat_valid === 1'b1) obs_beats++;
    if (done === 1'b1) obs_dones++;
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; vl_in = '0; vm_ena_in = 0; mask_pair = 2'b00;
    lane_busy = 0; stall = 0; flush = 0;
  endtask

  task automatic issue(input int vl, input bit vm);
    start = 1; vl_in = VL_W'(vl); vm_ena_in = vm;
    tick();
    start = 0; vl_in = '0; vm_ena_in = 0;
  endtask

  task automatic run_to_idle(input string tag);
    int n;
    n = 0;
    while (m_phase != 0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(m_phase == 0), 32'd1);
  endtask

  initial begin
    RST = 1;
    clear_inputs();
    @(posedge CLK);
    #1;
    tick();                 // reset state checked here
    RST = 0;
    tick();

    // vl=5 unmasked: 3 beats, one done.
    obs_beats = 0; obs_dones = 0;
    issue(5, 0);
    run_to_idle("vl5");
    tick();
    check("vl5_beats", 32'(obs_beats), 32'd3);
    check("vl5_dones", 32'(obs_dones), 32'd1);

    // vl=0: no beats, done straight away.
    obs_beats = 0; obs_dones = 0;
    issue(0, 0);
    check("vl0_done_next", 32'(done), 32'd1);
    run_to_idle("vl0");
    check("vl0_beats", 32'(obs_beats), 32'd0);
    check("vl0_dones", 32'(obs_dones), 32'd1);

    // vl=4 masked, masks 10 then 01.
    issue(4, 1);
    mask_pair = 2'b10;
    tick();
    mask_pair = 2'b01;
    tick();
    mask_pair = 2'b00;
    run_to_idle("vl4m");

    // vl=6 with lane_busy x3 on beat 2 and stall x1 on beat 3: 7 RUN cycles.
    obs_beats = 0; obs_dones = 0;
    issue(6, 0);
    tick();
    lane_busy = 1;
    repeat (3) tick();
    lane_busy = 0;
    tick();
    stall = 1;
    tick();
    stall = 0;
    run_to_idle("vl6hold");
    check("vl6hold_run_cycles", 32'(obs_beats), 32'd7);
    check("vl6hold_dones", 32'(obs_dones), 32'd1);

    // vl=8 flushed on beat 2, then vl=2 single beat.
    obs_beats = 0; obs_dones = 0;
    issue(8, 0);
    tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_ready", 32'(ready), 32'd1);
    issue(2, 0);
    run_to_idle("after_flush");
    check("flush_beats", 32'(obs_beats), 32'd3);
    check("flush_dones", 32'(obs_dones), 32'd1);

    // start during RUN is ignored.
    obs_beats = 0; obs_dones = 0;
    issue(6, 0);
    start = 1; vl_in = 8'd20; vm_ena_in = 1;
    tick();
    clear_inputs();
    run_to_idle("start_in_run");
    check("start_in_run_beats", 32'(obs_beats), 32'd3);

    // Reset mid-run.
    obs_dones = 0;
    issue(10, 1);
    tick();
    RST = 1;
    tick();
    RST = 0;
    tick();
    check("rst_mid_dones", 32'(obs_dones), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      vl_in     = ($urandom_range(0, 9) == 0) ? VL_W'($urandom_range(0, 255))
                                              : VL_W'($urandom_range(0, 12));
      vm_ena_in = $urandom_range(0, 1) == 1;
      mask_pair = 2'($urandom_range(0, 3));
      lane_busy = ($urandom_range(0, 4) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      RST       = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 0;
    clear_inputs();
    run_to_idle("random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
